// File: rtl/gobou_ctrl_seq.sv
// Layer sequencer for the gobou fully-connected engine: walks one job through
// all CORE-wide passes, emitting memory addresses and the beat control stream.
module gobou_ctrl_seq #(
  parameter int CORE    = 8,
  parameter int N_W     = 10,
  parameter int ADDR_W  = 12,
  parameter int WADDR_W = 16,
  parameter int D_DRAIN = 6
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [N_W-1:0]     n_in,
  input  logic [N_W-1:0]     n_out,
  input  logic [ADDR_W-1:0]  in_offset,
  input  logic [WADDR_W-1:0] w_offset,
  output logic               busy,
  output logic               ack,
  output logic [ADDR_W-1:0]  mem_in_addr,
  output logic [WADDR_W-1:0] mem_w_addr,
  output logic               ctrl_start,
  output logic               ctrl_valid,
  output logic               ctrl_stop,
  output logic               acc_clr,
  output logic [CORE-1:0]    out_mask,
  output logic [N_W-1:0]     pass_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DC_W = (D_DRAIN > 1) ? $clog2(D_DRAIN) : 1;

  logic [1:0]         state;
  logic [N_W-1:0]     n_in_q;
  logic [ADDR_W-1:0]  in_off_q;
  logic [WADDR_W-1:0] w_base;
  logic [N_W-1:0]     i_cnt;
  logic [N_W-1:0]     rem_q;
  logic [DC_W-1:0]    drain_cnt;

  logic [N_W-1:0]     i_next;
  logic [N_W-1:0]     rem_next;
  logic [WADDR_W-1:0] w_base_next;
  logic               last_pass;

  // rem_q counts output neurons not yet covered by earlier passes; this
  // replaces a ceil(n_out/CORE) divider and also drives the lane mask.
  function automatic logic [CORE-1:0] lane_mask(input logic [N_W-1:0] rem);
    logic [CORE-1:0] m;
    m = '0;
    for (int j = 0; j < CORE; j++) begin
      m[j] = (rem > N_W'(j));
    end
    return m;
  endfunction

  always_comb begin
    i_next      = i_cnt + N_W'(1);
    rem_next    = rem_q - N_W'(CORE);
    w_base_next = w_base + WADDR_W'(n_in_q);
    last_pass   = (rem_q <= N_W'(CORE));
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state       <= S_IDLE;
      n_in_q      <= '0;
      in_off_q    <= '0;
      w_base      <= '0;
      i_cnt       <= '0;
      rem_q       <= '0;
      drain_cnt   <= '0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      mem_in_addr <= '0;
      mem_w_addr  <= '0;
      ctrl_start  <= 1'b0;
      ctrl_valid  <= 1'b0;
      ctrl_stop   <= 1'b0;
      acc_clr     <= 1'b0;
      out_mask    <= '0;
      pass_idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            n_in_q   <= n_in;
            in_off_q <= in_offset;
            rem_q    <= n_out;
            w_base   <= w_offset;
            i_cnt    <= '0;
            busy     <= 1'b1;
            if (n_in == '0 || n_out == '0) begin
              state <= S_DONE;
              ack   <= 1'b1;
            end else begin
              // Beat (0,0) is registered here so it is visible the next cycle.
              state       <= S_MAC;
              mem_in_addr <= in_offset;
              mem_w_addr  <= w_offset;
              pass_idx    <= '0;
              ctrl_valid  <= 1'b1;
              ctrl_start  <= 1'b1;
              acc_clr     <= 1'b1;
              ctrl_stop   <= (n_in == N_W'(1));
              out_mask    <= lane_mask(n_out);
            end
          end
        end
        S_MAC: begin
          if (ctrl_stop) begin
            if (last_pass) begin
              state      <= S_DRAIN;
              ctrl_valid <= 1'b0;
              ctrl_start <= 1'b0;
              ctrl_stop  <= 1'b0;
              acc_clr    <= 1'b0;
              drain_cnt  <= DC_W'(D_DRAIN - 1);
            end else begin
              // Next pass starts on the very next beat; w_base tracks p*n_in.
              i_cnt       <= '0;
              rem_q       <= rem_next;
              w_base      <= w_base_next;
              mem_in_addr <= in_off_q;
              mem_w_addr  <= w_base_next;
              pass_idx    <= pass_idx + N_W'(1);
              ctrl_start  <= 1'b1;
              acc_clr     <= 1'b1;
              ctrl_stop   <= (n_in_q == N_W'(1));
              out_mask    <= lane_mask(rem_next);
            end
          end else begin
            i_cnt       <= i_next;
            mem_in_addr <= mem_in_addr + ADDR_W'(1);
            mem_w_addr  <= mem_w_addr + WADDR_W'(1);
            ctrl_start  <= 1'b0;
            acc_clr     <= 1'b0;
            ctrl_stop   <= (i_next == n_in_q - N_W'(1));
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_DONE;
            ack   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DC_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gobou_ctrl_seq.sv
// Directed self-checking bench for gobou_ctrl_seq: beat streams, ack timing,
// degenerate jobs, mid-job reset, request collisions and address wrap.
module tb_gobou_ctrl_seq;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        req = 1'b0;
  logic [9:0]  n_in = '0;
  logic [9:0]  n_out = '0;
  logic [11:0] in_offset = '0;
  logic [15:0] w_offset = '0;
  logic        busy, ack, ctrl_start, ctrl_valid, ctrl_stop, acc_clr;
  logic [11:0] mem_in_addr;
  logic [15:0] mem_w_addr;
  logic [7:0]  out_mask;
  logic [9:0]  pass_idx;

  gobou_ctrl_seq dut (
    .clk(clk), .xrst(xrst), .req(req), .n_in(n_in), .n_out(n_out),
    .in_offset(in_offset), .w_offset(w_offset), .busy(busy), .ack(ack),
    .mem_in_addr(mem_in_addr), .mem_w_addr(mem_w_addr),
    .ctrl_start(ctrl_start), .ctrl_valid(ctrl_valid), .ctrl_stop(ctrl_stop),
    .acc_clr(acc_clr), .out_mask(out_mask), .pass_idx(pass_idx)
  );

  typedef struct {
    int          cyc;
    logic [11:0] ia;
    logic [15:0] wa;
    logic        st;
    logic        sp;
    logic        clr;
    logic [7:0]  m;
    logic [9:0]  pi;
  } beat_t;

  beat_t beats[$];
  int    ack_cyc[$];
  int    busy_first = -1;
  int    busy_last = -1;
  int    cyc = 0;
  int    t0 = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every observable event mid-cycle, tagged with its cycle number.
  always @(negedge clk) begin
    if (ctrl_valid)
      beats.push_back('{cyc, mem_in_addr, mem_w_addr, ctrl_start, ctrl_stop,
                        acc_clr, out_mask, pass_idx});
    if (ack) ack_cyc.push_back(cyc);
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clearLog();
    beats.delete();
    ack_cyc.delete();
    busy_first = -1;
    busy_last = -1;
  endtask

  // Raises req for the edge that accepts the job; cycle t+k is cyc == t0+k.
  task automatic applyStimulus(input logic [9:0] ni, input logic [9:0] no,
                               input logic [11:0] io, input logic [15:0] wo,
                               input bit hold);
    @(negedge clk);
    n_in = ni; n_out = no; in_offset = io; w_offset = wo;
    req = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    clearLog();
    if (!hold) req = 1'b0;
    n_in = 10'h3a5; n_out = 10'h2c1; in_offset = 12'h5a5; w_offset = 16'hbeef;
  endtask

  task automatic waitAck(input int budget, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, " ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [7:0] mask_t2 [3];
    logic [7:0] mask_t5 [2];
    logic [11:0] ia_t8 [4];
    bit found;
    mask_t2 = '{8'hFF, 8'hFF, 8'h0F};
    mask_t5 = '{8'hFF, 8'h03};
    ia_t8   = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst ctrl", {busy, ack, ctrl_valid, ctrl_start, ctrl_stop, acc_clr}, 0);
    checkOutput("rst in_addr", mem_in_addr, 0);
    checkOutput("rst w_addr", mem_w_addr, 0);
    checkOutput("rst mask_pass", {out_mask, pass_idx}, 0);
    xrst = 1'b1;
    repeat (2) @(negedge clk);

    // Single pass
    applyStimulus(10'd4, 10'd8, 12'd0, 16'd0, 1'b0);
    waitAck(60, "t1");
    checkOutput("t1 beats", beats.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < beats.size()) begin
        checkOutput($sformatf("t1 cyc[%0d]", k), beats[k].cyc, t0 + 1 + k);
        checkOutput($sformatf("t1 ia[%0d]", k), beats[k].ia, k);
        checkOutput($sformatf("t1 wa[%0d]", k), beats[k].wa, k);
        checkOutput($sformatf("t1 st_sp[%0d]", k), {beats[k].st, beats[k].sp},
                    {k == 0, k == 3});
        checkOutput($sformatf("t1 mask[%0d]", k), beats[k].m, 8'hFF);
      end
    end
    checkOutput("t1 ack_cyc", ack_cyc.size() > 0 ? ack_cyc[0] : -1, t0 + 11);
    checkOutput("t1 busy_first", busy_first, t0 + 1);
    checkOutput("t1 busy_last", busy_last, t0 + 11);

    // Multi-pass with partial last pass
    applyStimulus(10'd3, 10'd20, 12'd0, 16'd100, 1'b0);
    waitAck(80, "t2");
    checkOutput("t2 beats", beats.size(), 9);
    for (int k = 0; k < 9; k++) begin
      if (k < beats.size()) begin
        checkOutput($sformatf("t2 cyc[%0d]", k), beats[k].cyc, t0 + 1 + k);
        checkOutput($sformatf("t2 ia[%0d]", k), beats[k].ia, k % 3);
        checkOutput($sformatf("t2 wa[%0d]", k), beats[k].wa, 100 + k);
        checkOutput($sformatf("t2 pass[%0d]", k), beats[k].pi, k / 3);
        checkOutput($sformatf("t2 mask[%0d]", k), beats[k].m, mask_t2[k / 3]);
        checkOutput($sformatf("t2 st_sp_clr[%0d]", k),
                    {beats[k].st, beats[k].sp, beats[k].clr},
                    {k % 3 == 0, k % 3 == 2, k % 3 == 0});
      end
    end
    checkOutput("t2 ack_cyc", ack_cyc.size() > 0 ? ack_cyc[0] : -1, t0 + 16);

    // n_in = 1: every beat is both first and last of its pass
    applyStimulus(10'd1, 10'd16, 12'd0, 16'd0, 1'b0);
    waitAck(60, "t3");
    checkOutput("t3 beats", beats.size(), 2);
    for (int k = 0; k < 2; k++) begin
      if (k < beats.size()) begin
        checkOutput($sformatf("t3 st_sp[%0d]", k), {beats[k].st, beats[k].sp}, 2'b11);
        checkOutput($sformatf("t3 wa_pass[%0d]", k), {beats[k].wa, 6'd0, beats[k].pi},
                    {16'(k), 6'd0, 10'(k)});
      end
    end

    // Zero-length jobs acknowledge immediately
    applyStimulus(10'd0, 10'd5, 12'd0, 16'd0, 1'b0);
    waitAck(10, "t4a");
    checkOutput("t4a beats", beats.size(), 0);
    checkOutput("t4a ack_cyc", ack_cyc.size() > 0 ? ack_cyc[0] : -1, t0 + 1);
    checkOutput("t4a busy", {16'(busy_first), 16'(busy_last)},
                {16'(t0 + 1), 16'(t0 + 1)});
    applyStimulus(10'd4, 10'd0, 12'd0, 16'd0, 1'b0);
    waitAck(10, "t4b");
    checkOutput("t4b beats", beats.size(), 0);
    checkOutput("t4b ack_cyc", ack_cyc.size() > 0 ? ack_cyc[0] : -1, t0 + 1);

    // Reset during pass 1 aborts the job
    applyStimulus(10'd3, 10'd20, 12'd0, 16'd100, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (ctrl_valid && pass_idx == 10'd1) found = 1'b1;
    end
    checkOutput("t5 reached_pass1", 32'(found), 1);
    xrst = 1'b0;
    #1;
    checkOutput("t5 ctrl", {busy, ack, ctrl_valid, ctrl_start, ctrl_stop, acc_clr}, 0);
    checkOutput("t5 addrs", {mem_in_addr, mem_w_addr}, 0);
    checkOutput("t5 mask_pass", {out_mask, pass_idx}, 0);
    clearLog();
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t5 no_beats", beats.size(), 0);
    checkOutput("t5 no_ack", ack_cyc.size(), 0);
    applyStimulus(10'd2, 10'd10, 12'd7, 16'd50, 1'b0);
    waitAck(60, "t5b");
    checkOutput("t5b beats", beats.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < beats.size()) begin
        checkOutput($sformatf("t5b ia[%0d]", k), beats[k].ia, 7 + k % 2);
        checkOutput($sformatf("t5b wa[%0d]", k), beats[k].wa, 50 + k);
        checkOutput($sformatf("t5b mask[%0d]", k), beats[k].m, mask_t5[k / 2]);
      end
    end
    checkOutput("t5b ack_cyc", ack_cyc.size() > 0 ? ack_cyc[0] : -1, t0 + 11);

    // req toggled while busy is ignored
    applyStimulus(10'd3, 10'd20, 12'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    req = 1'b1;
    repeat (2) @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    waitAck(60, "t6");
    repeat (5) @(negedge clk);
    checkOutput("t6 beats", beats.size(), 9);
    checkOutput("t6 acks", ack_cyc.size(), 1);
    checkOutput("t6 ack_cyc", ack_cyc.size() > 0 ? ack_cyc[0] : -1, t0 + 16);

    // req held high: back-to-back jobs, second one sampling new config
    applyStimulus(10'd2, 10'd8, 12'd0, 16'd0, 1'b1);
    n_in = 10'd3; n_out = 10'd8; in_offset = 12'd0; w_offset = 16'd0;
    waitAck(60, "t7a");
    @(posedge clk);
    #1;
    req = 1'b0;
    waitAck(60, "t7b");
    checkOutput("t7 beats", beats.size(), 5);
    checkOutput("t7 acks", ack_cyc.size(), 2);
    if (beats.size() == 5) begin
      checkOutput("t7 cyc1", beats[1].cyc, t0 + 2);
      checkOutput("t7 cyc2", beats[2].cyc, t0 + 11);
      checkOutput("t7 cyc4", beats[4].cyc, t0 + 13);
      checkOutput("t7 wa4", beats[4].wa, 2);
    end
    if (ack_cyc.size() == 2) begin
      checkOutput("t7 ack0", ack_cyc[0], t0 + 9);
      checkOutput("t7 ack1", ack_cyc[1], t0 + 20);
    end

    // Input address wraps modulo 2^12
    applyStimulus(10'd4, 10'd3, 12'hFFE, 16'd0, 1'b0);
    waitAck(60, "t8");
    checkOutput("t8 beats", beats.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < beats.size()) begin
        checkOutput($sformatf("t8 ia[%0d]", k), beats[k].ia, ia_t8[k]);
        checkOutput($sformatf("t8 mask[%0d]", k), beats[k].m, 8'h07);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
